// File: rtl/seu_count_collector.sv
// Polls a free-running SEU counter, accumulates modulo-2^W deltas into a
// saturating total, and serves read / clear requests from slow control.
module seu_count_collector #(
  parameter int SEUCNTWIDTH = 8,
  parameter int ACCWIDTH    = 32,
  parameter int POLLPERIOD  = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [SEUCNTWIDTH-1:0] seuCount,
  output logic                   seuCountRst,
  input  logic                   rdReq,
  output logic                   rdValid,
  output logic [ACCWIDTH-1:0]    rdData,
  input  logic                   clrReq,
  output logic [ACCWIDTH-1:0]    total,
  output logic                   saturated
);

  localparam int TIMERWIDTH = $clog2(POLLPERIOD);
  localparam logic [TIMERWIDTH-1:0] TIMERTERM = TIMERWIDTH'(POLLPERIOD - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, ACCUM, CLEAR} stateT;

  stateT                  state, stateNext;
  logic [TIMERWIDTH-1:0]  timer, timerNext;
  logic                   pendRd, pendRdNext;
  logic                   pendClr, pendClrNext;
  logic                   readPoll, readPollNext;
  logic [SEUCNTWIDTH-1:0] sample, last;
  logic [SEUCNTWIDTH-1:0] delta;
  logic [ACCWIDTH-1:0]    deltaExt;
  logic [ACCWIDTH:0]      sum;
  logic [ACCWIDTH-1:0]    totalUpd;

  // Modulo subtraction absorbs counter wrap between polls.
  always_comb begin
    delta                       = sample - last;
    deltaExt                    = '0;
    deltaExt[SEUCNTWIDTH-1:0]   = delta;
    sum                         = {1'b0, total} + {1'b0, deltaExt};
    totalUpd                    = sum[ACCWIDTH] ? '1 : sum[ACCWIDTH-1:0];
  end

  always_comb begin
    stateNext    = state;
    timerNext    = timer;
    pendRdNext   = pendRd;
    pendClrNext  = pendClr;
    readPollNext = readPoll;
    unique case (state)
      IDLE: begin
        if (clrReq || pendClr) begin
          // A read arriving alongside a clear is serviced after it.
          stateNext   = CLEAR;
          timerNext   = '0;
          pendClrNext = 1'b0;
          pendRdNext  = pendRd | rdReq;
        end else if (rdReq || pendRd) begin
          stateNext    = SAMPLE;
          timerNext    = '0;
          pendRdNext   = 1'b0;
          readPollNext = 1'b1;
        end else if (timer == TIMERTERM) begin
          stateNext    = SAMPLE;
          timerNext    = '0;
          readPollNext = 1'b0;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      SAMPLE: begin
        stateNext   = ACCUM;
        pendRdNext  = pendRd | rdReq;
        pendClrNext = pendClr | clrReq;
      end
      ACCUM: begin
        stateNext   = IDLE;
        pendRdNext  = pendRd | rdReq;
        pendClrNext = pendClr | clrReq;
      end
      CLEAR: begin
        stateNext   = IDLE;
        pendRdNext  = pendRd | rdReq;
        pendClrNext = pendClr | clrReq;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      timer       <= '0;
      pendRd      <= 1'b0;
      pendClr     <= 1'b0;
      readPoll    <= 1'b0;
      sample      <= '0;
      last        <= '0;
      total       <= '0;
      saturated   <= 1'b0;
      rdValid     <= 1'b0;
      rdData      <= '0;
      seuCountRst <= 1'b1;
    end else begin
      state       <= stateNext;
      timer       <= timerNext;
      pendRd      <= pendRdNext;
      pendClr     <= pendClrNext;
      readPoll    <= readPollNext;
      seuCountRst <= (stateNext == CLEAR);
      rdValid     <= 1'b0;
      case (state)
        SAMPLE: sample <= seuCount;
        ACCUM: begin
          last  <= sample;
          total <= totalUpd;
          if (sum[ACCWIDTH]) saturated <= 1'b1;
          if (readPoll) begin
            rdValid <= 1'b1;
            rdData  <= totalUpd;
          end
        end
        CLEAR: begin
          total     <= '0;
          last      <= '0;
          sample    <= '0;
          saturated <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
